// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hazard stall/flush, write-back destination resolution
// at capture, and a saturating counter of bubbles entering EX.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wr_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [REG_AW-1:0] wr_addr_s;
    logic [CTRL_W-1:0] ctrl_load_s;
    logic              bubble_s;
    logic              cnt_sat_s;

    // Destination resolution, RegWrite suppression and bubble detection
    always_comb begin
        wr_addr_s   = id_rt;
        ctrl_load_s = {CTRL_W{1'b0}};
        bubble_s    = 1'b0;
        cnt_sat_s   = (bubble_cnt == {CNT_W{1'b1}});
        if (id_ctrl[1]) begin
            wr_addr_s = id_rd;
        end else begin
            wr_addr_s = id_rt;
        end
        // Writes to register 0 are architecturally discarded, so drop RegWrite here
        if (id_valid) begin
            ctrl_load_s = {id_ctrl[CTRL_W-1:1],
                           id_ctrl[0] & (wr_addr_s != {REG_AW{1'b0}})};
        end else begin
            ctrl_load_s = {CTRL_W{1'b0}};
        end
        if (flush) begin
            bubble_s = 1'b1;
        end else if (!stall) begin
            bubble_s = ~id_valid;
        end else begin
            bubble_s = 1'b0;
        end
    end

    // EX-side pipeline state: flush beats stall beats load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc4     <= {DATA_W{1'b0}};
            ex_rs_data <= {DATA_W{1'b0}};
            ex_rt_data <= {DATA_W{1'b0}};
            ex_imm_ext <= {DATA_W{1'b0}};
            ex_rs      <= {REG_AW{1'b0}};
            ex_rt      <= {REG_AW{1'b0}};
            ex_wr_addr <= {REG_AW{1'b0}};
            ex_ctrl    <= {CTRL_W{1'b0}};
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_wr_addr <= {REG_AW{1'b0}};
            ex_ctrl    <= {CTRL_W{1'b0}};
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm_ext <= id_imm_ext;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wr_addr <= wr_addr_s;
            ex_ctrl    <= ctrl_load_s;
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= {CNT_W{1'b0}};
        end else if (bubble_s && !cnt_sat_s) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed cases plus random traffic against a
// behavioural model of the EX-side state.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm_ext = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [7:0]  id_ctrl = '0;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_wr_addr;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic        m_valid;
    logic [31:0] m_pc4, m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_wa;
    logic [7:0]  m_ctrl;
    int          m_cnt;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_ctrl(id_ctrl), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_wa = '0; m_ctrl = '0; m_cnt = 0;
    endtask

    // what EX should hold after one rising edge with the current inputs
    task automatic model_edge();
        logic [4:0] dest;
        if (flush) begin
            m_valid = 1'b0; m_ctrl = '0; m_wa = '0;
            if (m_cnt < 65535) m_cnt++;
        end else if (!stall) begin
            dest = id_ctrl[1] ? id_rd : id_rt;
            m_valid = id_valid; m_pc4 = id_pc4; m_rsd = id_rs_data; m_rtd = id_rt_data;
            m_imm = id_imm_ext; m_rs = id_rs; m_rt = id_rt; m_wa = dest;
            if (!id_valid) begin
                m_ctrl = 8'h00;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ctrl = id_ctrl;
                if (dest == 5'd0) m_ctrl[0] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
        chk({tag, ".pc4"}, ex_pc4, m_pc4);
        chk({tag, ".rs_data"}, ex_rs_data, m_rsd);
        chk({tag, ".rt_data"}, ex_rt_data, m_rtd);
        chk({tag, ".imm"}, ex_imm_ext, m_imm);
        chk({tag, ".rs"}, {27'd0, ex_rs}, {27'd0, m_rs});
        chk({tag, ".rt"}, {27'd0, ex_rt}, {27'd0, m_rt});
        chk({tag, ".wr_addr"}, {27'd0, ex_wr_addr}, {27'd0, m_wa});
        chk({tag, ".ctrl"}, {24'd0, ex_ctrl}, {24'd0, m_ctrl});
        chk({tag, ".bubble_cnt"}, {16'd0, bubble_cnt}, m_cnt[31:0]);
    endtask

    task automatic rand_id();
        id_valid   = ($urandom_range(0, 3) != 0);
        id_pc4     = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm_ext = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_ctrl = 8'($urandom);
        if ($urandom_range(0, 7) == 0) id_rt = 5'd0;
        if ($urandom_range(0, 7) == 0) id_rd = 5'd0;
    endtask

    // apply current inputs over one edge and compare every output
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // directed load: negative immediate, RegDst=1 selects rd
        id_valid = 1'b1; id_imm_ext = 32'hFFFF8000; id_ctrl = 8'h03;
        id_rd = 5'd9; id_rt = 5'd4; id_rs = 5'd7; id_rs_data = 32'h1234_5678;
        id_pc4 = 32'h0000_0104; id_rt_data = 32'hCAFE_0001;
        step("load_imm");
        chk("load_imm.fixed_wr", {27'd0, ex_wr_addr}, 32'd9);
        chk("load_imm.fixed_ctrl", {24'd0, ex_ctrl}, 32'h03);

        // asynchronous reset mid-stream, checked with no clock edge
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.fixed_valid", {31'd0, ex_valid}, 32'd0);
        #1 rst = 1'b0;

        // RegWrite to register 0 is suppressed
        id_valid = 1'b1; id_ctrl = 8'h01; id_rt = 5'd0; id_rd = 5'd12;
        step("dest_zero");
        chk("dest_zero.fixed_ctrl", {24'd0, ex_ctrl}, 32'h00);

        // load something distinctive then stall three cycles with changing inputs
        rand_id(); id_valid = 1'b1;
        step("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step("stall");
        end

        // stall and flush together: flush wins, one bubble counted
        flush = 1'b1; rand_id();
        step("stall_flush");
        stall = 1'b0; flush = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        stall = 1'b0; flush = 1'b0;

        // saturation: 65535 flushes from reset, then one more
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        #1 rst = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all("sat_fill");
        chk("sat_fill.fixed", {16'd0, bubble_cnt}, 32'h0000FFFF);
        step("sat_hold");
        chk("sat_hold.fixed", {16'd0, bubble_cnt}, 32'h0000FFFF);
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
